// File: rtl/axi4_rd_subordinate.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rd_subordinate
// Brief    : AXI4 read subordinate over a 1-cycle-latency memory port with a
//            4-entry R FIFO. Optional macro AXI4_RD_SUB_PAGE_CHECK_EN makes
//            4 KB-crossing INCR bursts illegal (SLVERR).
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rd_subordinate #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ADD_W  = 32,
  parameter int AXI_DATA_W = 256,
  parameter int MEM_ADD_W  = 16
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic [AXI_ID_W-1:0]   s_axi_arid,
  input  logic [AXI_ADD_W-1:0]  s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_ID_W-1:0]   s_axi_rid,
  output logic [AXI_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_rd_en,
  output logic [MEM_ADD_W-1:0]  mem_rd_add,
  input  logic [AXI_DATA_W-1:0] mem_rd_data
);

  localparam int DATA_BYTES = AXI_DATA_W / 8;
  localparam int SIZE_LOG2  = $clog2(DATA_BYTES);
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  out_of_rst;
  logic [AXI_ID_W-1:0]   id_q;
  logic [AXI_ADD_W-1:0]  addr_q;
  logic [AXI_ADD_W-1:0]  addr_nxt;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            burst_q;

  logic                  inflight_vld;
  logic [AXI_ID_W-1:0]   inflight_id;
  logic                  inflight_last;

  logic [2:0]            fifo_cnt;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [AXI_ID_W-1:0]   fifo_id   [FIFO_DEPTH];
  logic [AXI_DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [1:0]            fifo_resp [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];

  logic ar_hs;
  logic ar_illegal;
  logic size_bad, burst_bad, align_bad, wrap_bad, page_bad;
  logic credit;
  logic beat_last;
  logic issue;
  logic err_push;
  logic push, pop;
  logic [AXI_ADD_W-1:0] incr_addr;
  logic [AXI_ADD_W-1:0] wrap_mask;

  assign s_axi_arready = out_of_rst && (state == IDLE);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign beat_last     = (beat_cnt == len_q);
  // Reads in flight reserve a FIFO slot so backpressure can never drop a beat.
  assign credit        = (fifo_cnt + {2'b00, inflight_vld}) < 3'd4;

  // Request legality
  always_comb begin
    size_bad  = (s_axi_arsize != 3'(SIZE_LOG2));
    burst_bad = (s_axi_arburst == 2'b11);
    align_bad = (s_axi_araddr[SIZE_LOG2-1:0] != '0);
    wrap_bad  = (s_axi_arburst == BURST_WRAP) &&
                !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                  (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15));
`ifdef AXI4_RD_SUB_PAGE_CHECK_EN
    page_bad  = (s_axi_arburst == BURST_INCR) &&
                (({20'd0, s_axi_araddr[11:0]} +
                  (({24'd0, s_axi_arlen} + 32'd1) << SIZE_LOG2)) > 32'd4096);
`else
    page_bad  = 1'b0;
`endif
    ar_illegal = size_bad || burst_bad || align_bad || wrap_bad || page_bad;
  end

  // Legal WRAP lengths make the window (len+1)*DATA_BYTES a power of two.
  always_comb begin
    incr_addr = addr_q + AXI_ADD_W'(DATA_BYTES);
    wrap_mask = (AXI_ADD_W'(len_q) << SIZE_LOG2) | AXI_ADD_W'(DATA_BYTES - 1);
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     addr_nxt = incr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    err_push  = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) state_nxt = ar_illegal ? ERR : RUN;
      end
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (beat_last) state_nxt = IDLE;
        end
      end
      ERR: begin
        if (credit && !inflight_vld) begin
          err_push = 1'b1;
          if (beat_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_rd_en  = issue;
  assign mem_rd_add = addr_q[SIZE_LOG2 +: MEM_ADD_W];

  assign push = inflight_vld || err_push;
  assign pop  = s_axi_rvalid && s_axi_rready;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      out_of_rst    <= 1'b0;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      burst_q       <= '0;
      beat_cnt      <= '0;
      inflight_vld  <= 1'b0;
      inflight_id   <= '0;
      inflight_last <= 1'b0;
      fifo_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      out_of_rst <= 1'b1;
      if (ar_hs) begin
        id_q     <= s_axi_arid;
        addr_q   <= s_axi_araddr;
        len_q    <= s_axi_arlen;
        burst_q  <= s_axi_arburst;
        beat_cnt <= '0;
      end else if (issue || err_push) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (issue) addr_q <= addr_nxt;
      end
      inflight_vld <= issue;
      if (issue) begin
        inflight_id   <= id_q;
        inflight_last <= beat_last;
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Returning memory data takes priority; an ERR beat never coincides with it.
  always_ff @(posedge clk) begin
    if (push) begin
      if (inflight_vld) begin
        fifo_id[wr_ptr]   <= inflight_id;
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_resp[wr_ptr] <= RESP_OKAY;
        fifo_last[wr_ptr] <= inflight_last;
      end else begin
        fifo_id[wr_ptr]   <= id_q;
        fifo_data[wr_ptr] <= '0;
        fifo_resp[wr_ptr] <= RESP_SLVERR;
        fifo_last[wr_ptr] <= beat_last;
      end
    end
  end

  assign s_axi_rvalid = (fifo_cnt != 3'd0);
  assign s_axi_rid    = s_axi_rvalid ? fifo_id[rd_ptr]   : '0;
  assign s_axi_rdata  = s_axi_rvalid ? fifo_data[rd_ptr] : '0;
  assign s_axi_rresp  = s_axi_rvalid ? fifo_resp[rd_ptr] : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid ? fifo_last[rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_subordinate.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_rd_subordinate
// Brief    : Scoreboard bench for axi4_rd_subordinate with directed AR vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi4_rd_subordinate;

  logic         clk = 1'b0;
  logic         a_rst_n = 1'b0;
  logic [3:0]   arid = '0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic [2:0]   arsize = '0;
  logic [1:0]   arburst = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [3:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b1;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_add;
  logic [255:0] mem_rd_data = '0;

  axi4_rd_subordinate dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_add(mem_rd_add), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
    int           cyc;
  } beat_t;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } rd_t;

  beat_t       beat_q[$];
  rd_t         mem_q[$];
  logic [15:0] exp_words[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads = 0;
  int okay_pops = 0;
  int pops = 0;
  int rmode = 0;
  bit hold_pending = 0;
  logic [3:0]   h_id;
  logic [255:0] h_data;
  logic [1:0]   h_resp;
  logic         h_last;

  function automatic logic [255:0] pat(input logic [15:0] w);
    pat = {8{16'hC0DE, w}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pat(mem_rd_add);

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rready = 1'b1;
      1:       rready = ~rready;
      default: rready = 1'b0;
    endcase
  end

  // Monitor: memory reads, R hold stability, and beat scoreboard.
  always @(negedge clk) begin
    if (a_rst_n) begin
      if (mem_rd_en) begin
        rd_t e;
        reads++;
        checks++;
        if (reads - okay_pops > 4) begin
          errors++;
          $display("FAIL credit outstanding=%0d required<=4", reads - okay_pops);
        end
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_rd unexpected add=%0h cyc=%0d", mem_rd_add, cyc);
        end else begin
          e = mem_q.pop_front();
          if (mem_rd_add !== e.addr || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL mem_rd add=%0h required=%0h cyc=%0d required=%0d",
                     mem_rd_add, e.addr, cyc, e.cyc);
          end
        end
      end
      if (hold_pending) begin
        checks++;
        if (!rvalid || rid !== h_id || rdata !== h_data || rresp !== h_resp || rlast !== h_last) begin
          errors++;
          $display("FAIL r_hold valid=%0b id=%0h/%0h resp=%0h/%0h last=%0b/%0b", rvalid,
                   rid, h_id, rresp, h_resp, rlast, h_last);
        end
      end
      hold_pending = rvalid && !rready;
      h_id = rid; h_data = rdata; h_resp = rresp; h_last = rlast;
      if (rvalid && rready) begin
        beat_t b;
        pops++;
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL r_beat unexpected id=%0h resp=%0h", rid, rresp);
        end else begin
          b = beat_q.pop_front();
          if (rresp == 2'b00) okay_pops++;
          if (rid !== b.id || rdata !== b.data || rresp !== b.resp || rlast !== b.last ||
              (b.cyc >= 0 && cyc != b.cyc)) begin
            errors++;
            $display("FAIL r_beat id=%0h/%0h resp=%0h/%0h last=%0b/%0b cyc=%0d/%0d data=%0h/%0h",
                     rid, b.id, rresp, b.resp, rlast, b.last, cyc, b.cyc, rdata, b.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one AR; exp_words holds hand-computed word addresses of an OKAY burst.
  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst,
                       input bit err, input bit timed);
    int n = 0;
    int t;
    beat_t b;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_accept timeout id=%0h", id);
      arvalid = 1'b0;
      return;
    end
    t = cyc;
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      if (err) begin
        b.resp = 2'b10;
        b.data = '0;
        b.cyc  = timed ? t + 2 + i : -1;
      end else begin
        b.resp = 2'b00;
        b.data = pat(exp_words[i]);
        b.cyc  = timed ? t + 3 + i : -1;
        mem_q.push_back('{exp_words[i], timed ? t + 1 + i : -1});
      end
      beat_q.push_back(b);
    end
    exp_words.delete();
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((beat_q.size() != 0 || mem_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (beat_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain beats_left=%0d reads_left=%0d required=0", name,
               beat_q.size(), mem_q.size());
      beat_q.delete();
      mem_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    repeat (2) @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_mem_rd_add", mem_rd_add, 0);
    #2 a_rst_n = 1'b1;
    #1 chk("rel_arready_low", arready, 0);
    @(negedge clk);
    chk("rel_arready_high", arready, 1);

    exp_words = '{16'd2, 16'd3, 16'd4, 16'd5};
    issue(4'h5, 32'h40, 8'd3, 3'd5, 2'b01, 0, 1);
    drain("incr");

    exp_words = '{16'd3, 16'd0, 16'd1, 16'd2};
    issue(4'h6, 32'h60, 8'd3, 3'd5, 2'b10, 0, 0);
    drain("wrap");

    issue(4'h7, 32'h0, 8'd2, 3'd4, 2'b01, 1, 1);
    drain("bad_size");

`ifdef AXI4_RD_SUB_PAGE_CHECK_EN
    issue(4'h8, 32'hFC0, 8'd3, 3'd5, 2'b01, 1, 0);
`else
    exp_words = '{16'h7E, 16'h7F, 16'h80, 16'h81};
    issue(4'h8, 32'hFC0, 8'd3, 3'd5, 2'b01, 0, 0);
`endif
    drain("page");

    exp_words = '{16'h10};
    issue(4'h9, 32'h200, 8'd0, 3'd5, 2'b01, 0, 1);
    drain("len0");

    issue(4'hA, 32'h0, 8'd1, 3'd5, 2'b11, 1, 0);
    issue(4'hB, 32'h44, 8'd0, 3'd5, 2'b01, 1, 0);
    issue(4'hD, 32'h80, 8'd2, 3'd5, 2'b10, 1, 0);
    drain("illegal");

    exp_words = '{16'h80, 16'h81};
    issue(4'h1, 32'h1000, 8'd1, 3'd5, 2'b01, 0, 0);
    exp_words = '{16'h100, 16'h101};
    issue(4'h2, 32'h2000, 8'd1, 3'd5, 2'b01, 0, 0);
    drain("b2b");

    rmode = 1;
    exp_words = '{16'h18, 16'h18, 16'h18, 16'h18, 16'h18, 16'h18, 16'h18, 16'h18};
    issue(4'h3, 32'h300, 8'd7, 3'd5, 2'b00, 0, 0);
    drain("fixed_toggle");

    rmode = 2;
    exp_words = '{16'h20, 16'h21, 16'h22, 16'h23, 16'h24, 16'h25, 16'h26, 16'h27};
    issue(4'hE, 32'h400, 8'd7, 3'd5, 2'b01, 0, 0);
    repeat (12) @(negedge clk);
    chk("stall_reads", reads - okay_pops, 4);
    chk("stall_arready", arready, 0);
    rmode = 0;
    drain("stall");

    exp_words = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    base = pops;
    issue(4'h4, 32'h0, 8'd7, 3'd5, 2'b01, 0, 0);
    n = 0;
    while (pops < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 a_rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 0);
    chk("midrst_mem_rd_en", mem_rd_en, 0);
    beat_q.delete();
    mem_q.delete();
    hold_pending = 0;
    reads = 0;
    okay_pops = 0;
    @(negedge clk);
    #2 a_rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_arready", arready, 1);
    exp_words = '{16'd4, 16'd5};
    issue(4'hC, 32'h80, 8'd1, 3'd5, 2'b01, 0, 1);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_rd_subordinate.md
# axi4_rd_subordinate

AXI4 read-channel subordinate (responder) that serves AR requests from an AXI4 manager by reading a single-cycle-latency synchronous memory port and returning R beats. It sits between the HPU's AXI read managers (or a test interconnect) and on-chip RAM/regfile storage. It decodes FIXED/INCR/WRAP bursts, flags illegal requests with SLVERR, and buffers read data so that R-channel backpressure never drops a beat.

## Interface
- AXI_ID_W, 4, ARID/RID width
- AXI_ADD_W, 32, byte address width
- AXI_DATA_W, 256, data width; power of 2, ≥ 32; DATA_BYTES = AXI_DATA_W/8
- MEM_ADD_W, 16, word address width of memory port; mem word = AXI_DATA_W
- clk  in  1  clock
- a_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- s_axi_arid  in  AXI_ID_W  request ID
- s_axi_araddr  in  AXI_ADD_W  start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_arvalid  in  1 / s_axi_arready  out  1  AR handshake
- s_axi_rid  out  AXI_ID_W  echoed ID
- s_axi_rdata  out  AXI_DATA_W  read data
- s_axi_rresp  out  2  OKAY 00 / SLVERR 10
- s_axi_rlast  out  1  final beat of burst
- s_axi_rvalid  out  1 / s_axi_rready  in  1  R handshake
- mem_rd_en  out  1  memory read strobe
- mem_rd_add  out  MEM_ADD_W  word address = byte address >> log2(DATA_BYTES), truncated
- mem_rd_data  in  AXI_DATA_W  valid exactly 1 cycle after mem_rd_en

## Operation
- FSM: IDLE, RUN, ERR. arready = 1 only in IDLE (and not in reset).
- AR accept in IDLE: latch id, addr, len, burst; run checks; → RUN if legal, → ERR if illegal.
- Illegal (any one): arsize ≠ log2(DATA_BYTES); arburst = 11; araddr not DATA_BYTES-aligned; WRAP with arlen ∉ {1,3,7,15}; INCR burst whose last byte lies in a different 4096-byte page than the first (macro-dependent, see Configuration).
- RUN: each cycle where credit available, assert mem_rd_en, push beat tag {id, last, OKAY}; advance address. FIXED: unchanged. INCR: +DATA_BYTES. WRAP: +DATA_BYTES within wrap window of size (len+1)·DATA_BYTES aligned to that size; crossing upper bound wraps to window base. Tag last=1 on beat len; then → IDLE.
- ERR: no memory reads; emit len+1 beats with rdata = 0, rresp = SLVERR, correct rid, rlast on final; then → IDLE.
- Output FIFO depth 4, entries {id, data, resp, last}. Credit: occupancy + reads in flight < 4 required to issue a beat. Memory data written to FIFO the cycle it is valid. R outputs driven from FIFO head; pop on rvalid & rready.
- AXI rule: once rvalid = 1, rid/rdata/rresp/rlast hold until rready.
- New AR may be accepted while previous burst's beats still drain from FIFO; R beats stay in request order.

## Timing
- Reset (async assert, sync release): arready, rvalid, rlast, mem_rd_en = 0; rid, rdata, rresp, mem_rd_add = 0; FIFO empty; FSM IDLE. arready rises first cycle after release.
- AR handshake in cycle T → first mem_rd_en at T+1 → data into FIFO at T+2 → rvalid = 1 at T+3.
- With rready held high: 1 beat/cycle sustained, burst of N beats completes rlast at T+2+N; next AR accepted at T+1+N (cycle after last read issued).
- ERR bursts: first rvalid at T+2, then 1 beat/cycle.
- rready low: reads stall once credit exhausted; no beat lost or duplicated; resume on next pop.
- arlen = 0: single beat, rlast = 1 on it; FSM returns IDLE after one issue.
- Reset mid-burst: all in-flight state and FIFO discarded; outputs return to reset values asynchronously.

## Configuration
- AXI4_RD_SUB_PAGE_CHECK_EN defined: INCR burst crossing a 4096-byte boundary is illegal → ERR path (SLVERR beats).
- Undefined: page crossing permitted; address increments linearly across the page; OKAY responses.

## Test plan
- INCR, addr 0x0000_0040, len 3, rready high → mem_rd_add 2,3,4,5 on T+1..T+4; 4 OKAY beats T+3..T+6, rlast on 4th, rid echoed.
- WRAP, addr 0x60, len 3 (DATA_BYTES 32) → mem_rd_add 3,0,1,2; rlast on 4th beat.
- arsize = 4 with 256-bit bus → 1+len SLVERR beats, rdata 0, mem_rd_en never asserted.
- INCR addr 0xFC0, len 3: macro defined → 4 SLVERR beats; undefined → word addrs 0x7E..0x81, OKAY.
- FIXED, len 7, rready toggled 1-0-1-0 → mem_rd_add constant, exactly 8 beats, stable outputs while rready low, FIFO never exceeds 4.
- a_rst_n pulsed low during beat 2 of len 7 burst → rvalid/arready 0 immediately; after release new AR served correctly.
